// File: rtl/led_bus_arbiter.sv
// Two-requester arbiter sharing one LED peripheral over a 4-way handshake.
// Alternates on contention, and a watchdog aborts transactions the slave never acknowledges.
module led_bus_arbiter #(
  parameter int WIDTH   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] m0_dataIn,
  input  logic             m0_Write,
  input  logic             m0_Read,
  output logic [WIDTH-1:0] m0_dataOut,
  output logic             m0_Ready,
  input  logic [WIDTH-1:0] m1_dataIn,
  input  logic             m1_Write,
  input  logic             m1_Read,
  output logic [WIDTH-1:0] m1_dataOut,
  output logic             m1_Ready,
  output logic [WIDTH-1:0] s_dataIn,
  output logic             s_Write,
  output logic             s_Read,
  input  logic [WIDTH-1:0] s_dataOut,
  input  logic             s_Ready,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD, S_DRAIN} state_t;

  state_t      r_state, w_next;
  logic        r_gnt, r_last, r_timeout;
  logic [15:0] r_cnt;

  logic             w_req0, w_req1, w_gnt_sel;
  logic             w_g_write, w_g_read, w_g_req;
  logic [WIDTH-1:0] w_g_data;
  logic             w_hit, w_abort;

  assign w_req0    = m0_Write | m0_Read;
  assign w_req1    = m1_Write | m1_Read;
  // On contention the requester not served last wins; otherwise the sole requester.
  assign w_gnt_sel = (w_req0 & w_req1) ? ~r_last : w_req1;

  assign w_g_write = r_gnt ? m1_Write  : m0_Write;
  assign w_g_read  = r_gnt ? m1_Read   : m0_Read;
  assign w_g_data  = r_gnt ? m1_dataIn : m0_dataIn;
  assign w_g_req   = w_g_write | w_g_read;

  assign w_hit     = (r_cnt + 16'd1) == 16'(TIMEOUT);

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE:   if (w_req0 | w_req1) w_next = S_ACTIVE;
      S_ACTIVE: begin
        if (s_Ready)       w_next = S_HOLD;
        else if (!w_g_req) w_next = S_DRAIN;
        else if (w_hit) begin
          w_next  = S_DRAIN;
          w_abort = 1'b1;
        end
      end
      S_HOLD:   if (!w_g_req) w_next = S_DRAIN;
      S_DRAIN:  if (!s_Ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_Write  = 1'b0;
    s_Read   = 1'b0;
    s_dataIn = '0;
    m0_Ready = 1'b0;
    m1_Ready = 1'b0;
    if (r_state == S_ACTIVE || r_state == S_HOLD) begin
      s_Write  = w_g_write;
      s_Read   = w_g_read;
      s_dataIn = w_g_data;
    end
    if (r_state != S_IDLE) begin
      if (r_gnt) m1_Ready = s_Ready;
      else       m0_Ready = s_Ready;
    end
  end

  assign m0_dataOut = s_dataOut;
  assign m1_dataOut = s_dataOut;
  assign timeout    = r_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_abort;
      if (r_state == S_IDLE && w_next == S_ACTIVE) begin
        r_gnt <= w_gnt_sel;
        r_cnt <= '0;
      end else if (r_state == S_ACTIVE) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (r_state == S_DRAIN && !s_Ready) r_last <= r_gnt;
    end
  end

endmodule

// File: tb/tb_led_bus_arbiter.sv
// Directed bench for led_bus_arbiter with a registered-acknowledge LED slave model.
module tb_led_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] m0_dataIn, m1_dataIn, m0_dataOut, m1_dataOut;
  logic        m0_Write, m0_Read, m0_Ready, m1_Write, m1_Read, m1_Ready;
  logic [13:0] s_dataIn, s_dataOut;
  logic        s_Write, s_Read, s_Ready, timeout;
  logic        slv_en;

  int n_checks = 0;
  int n_fail   = 0;

  led_bus_arbiter #(.WIDTH(14), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_dataIn(m0_dataIn), .m0_Write(m0_Write), .m0_Read(m0_Read),
    .m0_dataOut(m0_dataOut), .m0_Ready(m0_Ready),
    .m1_dataIn(m1_dataIn), .m1_Write(m1_Write), .m1_Read(m1_Read),
    .m1_dataOut(m1_dataOut), .m1_Ready(m1_Ready),
    .s_dataIn(s_dataIn), .s_Write(s_Write), .s_Read(s_Read),
    .s_dataOut(s_dataOut), .s_Ready(s_Ready), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // LED slave: acknowledge is the strobe registered one cycle later
  always @(posedge clock) begin
    if (reset) s_Ready <= 1'b0;
    else       s_Ready <= slv_en & (s_Write | s_Read);
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    next_cycle(); reset = 1'b1;
    next_cycle(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m0_Write = 1'b1; m0_dataIn = 14'h3FFF;
    next_cycle(); next_cycle(); s_dataOut = 14'h1234;
    @(negedge clock);
    n_checks++; if (s_Write !== 1'b0) begin n_fail++; $display("FAIL rst_swrite: got %b exp 0", s_Write); end
    n_checks++; if (s_Read !== 1'b0) begin n_fail++; $display("FAIL rst_sread: got %b exp 0", s_Read); end
    n_checks++; if (s_dataIn !== 14'h0) begin n_fail++; $display("FAIL rst_sdata: got %h exp 0", s_dataIn); end
    n_checks++; if (m0_Ready !== 1'b0 || m1_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b%b exp 00", m0_Ready, m1_Ready); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b exp 0", timeout); end
    n_checks++; if (m0_dataOut !== 14'h1234 || m1_dataOut !== 14'h1234) begin n_fail++; $display("FAIL rst_dataout: got %h/%h exp 1234", m0_dataOut, m1_dataOut); end
    next_cycle(); reset = 1'b0; m0_Write = 1'b0; m0_dataIn = '0;
    @(negedge clock);
  endtask

  task automatic test_write_m0();
    next_cycle(); m0_Write = 1'b1; m0_dataIn = 14'h2A5A; @(negedge clock);
    n_checks++; if (s_Write !== 1'b0) begin n_fail++; $display("FAIL wr_c0_swrite: got %b exp 0", s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b1) begin n_fail++; $display("FAIL wr_c1_swrite: got %b exp 1", s_Write); end
    n_checks++; if (s_dataIn !== 14'h2A5A) begin n_fail++; $display("FAIL wr_c1_sdata: got %h exp 2a5a", s_dataIn); end
    n_checks++; if (m0_Ready !== 1'b0) begin n_fail++; $display("FAIL wr_c1_m0rdy: got %b exp 0", m0_Ready); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m0_Ready !== 1'b1) begin n_fail++; $display("FAIL wr_c2_m0rdy: got %b exp 1", m0_Ready); end
    n_checks++; if (m1_Ready !== 1'b0) begin n_fail++; $display("FAIL wr_c2_m1rdy: got %b exp 0", m1_Ready); end
    next_cycle(); m0_Write = 1'b0; m0_dataIn = '0; @(negedge clock);
    n_checks++; if (m0_Ready !== 1'b1 || s_Write !== 1'b0) begin n_fail++; $display("FAIL wr_c3_hold: got rdy=%b sw=%b exp 1/0", m0_Ready, s_Write); end
    n_checks++; if (m1_Ready !== 1'b0) begin n_fail++; $display("FAIL wr_c3_m1rdy: got %b exp 0", m1_Ready); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m0_Ready !== 1'b0 || s_Write !== 1'b0) begin n_fail++; $display("FAIL wr_c4_drain: got rdy=%b sw=%b exp 0/0", m0_Ready, s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b0 || m1_Ready !== 1'b0) begin n_fail++; $display("FAIL wr_c5_idle: got sw=%b m1r=%b exp 0/0", s_Write, m1_Ready); end
  endtask

  task automatic test_arbitration();
    apply_reset();
    next_cycle(); m0_Write = 1'b1; m0_dataIn = 14'h0AAA; m1_Write = 1'b1; m1_dataIn = 14'h1555; @(negedge clock);
    next_cycle(); @(negedge clock);
    n_checks++; if (s_dataIn !== 14'h0AAA) begin n_fail++; $display("FAIL arb_c1_first_m0: got %h exp 0aaa", s_dataIn); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m0_Ready !== 1'b1 || m1_Ready !== 1'b0) begin n_fail++; $display("FAIL arb_c2_ready: got %b%b exp 10", m0_Ready, m1_Ready); end
    next_cycle(); m0_Write = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    n_checks++; if (m1_Ready !== 1'b0 || s_Write !== 1'b0) begin n_fail++; $display("FAIL arb_c4_drain: got m1r=%b sw=%b exp 0/0", m1_Ready, s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b0) begin n_fail++; $display("FAIL arb_c5_idle: got %b exp 0", s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b1 || s_dataIn !== 14'h1555) begin n_fail++; $display("FAIL arb_c6_m1_active: got sw=%b d=%h exp 1/1555", s_Write, s_dataIn); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m1_Ready !== 1'b1 || m0_Ready !== 1'b0) begin n_fail++; $display("FAIL arb_c7_ready: got %b%b exp 01", m1_Ready, m0_Ready); end
    next_cycle(); m1_Write = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); m0_Write = 1'b1; m1_Write = 1'b1; @(negedge clock);
    next_cycle(); @(negedge clock);
    n_checks++; if (s_dataIn !== 14'h0AAA) begin n_fail++; $display("FAIL arb_c11_alt_m0: got %h exp 0aaa", s_dataIn); end
    next_cycle(); @(negedge clock);
    next_cycle(); m0_Write = 1'b0; m1_Write = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); @(negedge clock);
  endtask

  task automatic test_read_m1();
    next_cycle(); m1_Read = 1'b1; s_dataOut = 14'h0155; @(negedge clock);
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Read !== 1'b1 || s_Write !== 1'b0) begin n_fail++; $display("FAIL rd_c1_strobe: got r=%b w=%b exp 1/0", s_Read, s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m1_Ready !== 1'b1 || m0_Ready !== 1'b0) begin n_fail++; $display("FAIL rd_c2_ready: got m1=%b m0=%b exp 1/0", m1_Ready, m0_Ready); end
    n_checks++; if (m1_dataOut !== 14'h0155) begin n_fail++; $display("FAIL rd_c2_data: got %h exp 0155", m1_dataOut); end
    next_cycle(); m1_Read = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); @(negedge clock);
  endtask

  task automatic test_timeout();
    int pulses = 0;
    slv_en = 1'b0;
    next_cycle(); m0_Write = 1'b1; m0_dataIn = 14'h0F0F; @(negedge clock);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 5) m0_Write = 1'b0;
      @(negedge clock);
      if (timeout === 1'b1) pulses++;
      n_checks++; if (m0_Ready !== 1'b0) begin n_fail++; $display("FAIL to_c%0d_m0rdy: got %b exp 0", c, m0_Ready); end
      if (c == 4) begin
        n_checks++; if (s_Write !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_c4_active: got sw=%b to=%b exp 1/0", s_Write, timeout); end
      end
      if (c == 5) begin
        n_checks++; if (timeout !== 1'b1 || s_Write !== 1'b0) begin n_fail++; $display("FAIL to_c5_pulse: got to=%b sw=%b exp 1/0", timeout, s_Write); end
      end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL to_pulse_count: got %0d exp 1", pulses); end
    slv_en = 1'b1;
  endtask

  task automatic test_reset_in_hold();
    next_cycle(); m0_Write = 1'b1; m0_dataIn = 14'h0033; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); reset = 1'b1; @(negedge clock);
    n_checks++; if (s_Write !== 1'b1 || m0_Ready !== 1'b1) begin n_fail++; $display("FAIL rh_c3_hold: got sw=%b rdy=%b exp 1/1", s_Write, m0_Ready); end
    next_cycle(); reset = 1'b0; m0_Write = 1'b0; @(negedge clock);
    n_checks++; if (s_Write !== 1'b0 || s_Read !== 1'b0 || m0_Ready !== 1'b0 || m1_Ready !== 1'b0) begin n_fail++; $display("FAIL rh_c4_idle: got sw=%b sr=%b r0=%b r1=%b exp 0000", s_Write, s_Read, m0_Ready, m1_Ready); end
    next_cycle(); m1_Write = 1'b1; m1_dataIn = 14'h2222; @(negedge clock);
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b1 || s_dataIn !== 14'h2222) begin n_fail++; $display("FAIL rh_c6_m1: got sw=%b d=%h exp 1/2222", s_Write, s_dataIn); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m1_Ready !== 1'b1) begin n_fail++; $display("FAIL rh_c7_m1rdy: got %b exp 1", m1_Ready); end
    next_cycle(); m1_Write = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); @(negedge clock);
  endtask

  task automatic test_abandon();
    next_cycle(); m0_Write = 1'b1; m0_dataIn = 14'h0777; @(negedge clock);
    next_cycle(); m0_Write = 1'b0; @(negedge clock);
    n_checks++; if (s_Write !== 1'b0 || m0_Ready !== 1'b0) begin n_fail++; $display("FAIL ab_c1: got sw=%b rdy=%b exp 0/0", s_Write, m0_Ready); end
    // Re-asserting in the next cycle would pass through if HOLD were entered
    next_cycle(); m0_Write = 1'b1; @(negedge clock);
    n_checks++; if (s_Write !== 1'b0 || m0_Ready !== 1'b0) begin n_fail++; $display("FAIL ab_c2_drain: got sw=%b rdy=%b exp 0/0", s_Write, m0_Ready); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b0) begin n_fail++; $display("FAIL ab_c3_idle: got %b exp 0", s_Write); end
    next_cycle(); @(negedge clock);
    n_checks++; if (s_Write !== 1'b1 || s_dataIn !== 14'h0777) begin n_fail++; $display("FAIL ab_c4_regrant: got sw=%b d=%h exp 1/0777", s_Write, s_dataIn); end
    next_cycle(); @(negedge clock);
    n_checks++; if (m0_Ready !== 1'b1) begin n_fail++; $display("FAIL ab_c5_rdy: got %b exp 1", m0_Ready); end
    next_cycle(); m0_Write = 1'b0; @(negedge clock);
    next_cycle(); @(negedge clock);
    next_cycle(); @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired exp finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; slv_en = 1'b1; s_dataOut = '0;
    m0_dataIn = '0; m0_Write = 1'b0; m0_Read = 1'b0;
    m1_dataIn = '0; m1_Write = 1'b0; m1_Read = 1'b0;
    test_reset();
    test_write_m0();
    test_arbitration();
    test_read_m1();
    test_timeout();
    test_reset_in_hold();
    test_abandon();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
